// File: rtl/demux_1x2_buffered.sv
// Splits a serialized valid-qualified word stream back into two lanes, strictly
// alternating lane 0 / lane 1, with a small FIFO per lane drained by its own pop.
module demux_1x2_buffered #(
    parameter int WIDTH = 2,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             reset_L,
    input  logic [WIDTH-1:0] data_in,
    input  logic             valid_in,
    output logic             ready_in,
    input  logic             pop0,
    input  logic             pop1,
    output logic [WIDTH-1:0] data_out0,
    output logic [WIDTH-1:0] data_out1,
    output logic             valid_out0,
    output logic             valid_out1,
    output logic             full0,
    output logic             full1
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] COUNT_FULL = CW'(DEPTH);

    logic             r_sel;
    logic [WIDTH-1:0] r_mem    [2][DEPTH];
    logic [AW-1:0]    r_wr_ptr [2];
    logic [AW-1:0]    r_rd_ptr [2];
    logic [CW-1:0]    r_count  [2];

    logic             w_full   [2];
    logic             w_valid  [2];
    logic             w_push   [2];
    logic             w_pop    [2];
    logic             w_accept;

    // ready_in is a function of registered state only, so a pop never
    // combinationally opens the input path.
    always_comb begin
        for (int l = 0; l < 2; l++) begin
            w_full[l]  = (r_count[l] == COUNT_FULL);
            w_valid[l] = (r_count[l] != '0);
        end
        ready_in  = r_sel ? ~w_full[1] : ~w_full[0];
        w_accept  = valid_in & ready_in;
        w_push[0] = w_accept & ~r_sel;
        w_push[1] = w_accept & r_sel;
        w_pop[0]  = pop0 & w_valid[0];
        w_pop[1]  = pop1 & w_valid[1];
    end

    // NOTE: storage is reset too, so data_out reads 0 (not X) after reset
    // even though consumers are expected to qualify it with valid_out.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            r_sel <= 1'b0;
            for (int l = 0; l < 2; l++) begin
                r_wr_ptr[l] <= '0;
                r_rd_ptr[l] <= '0;
                r_count[l]  <= '0;
                for (int e = 0; e < DEPTH; e++) begin
                    r_mem[l][e] <= '0;
                end
            end
        end else begin
            // NOTE: non-blocking assignments throughout, so every lane sees
            // the pre-edge value of r_sel and the pointers.
            if (w_accept) begin
                r_sel <= ~r_sel;
            end
            for (int l = 0; l < 2; l++) begin
                if (w_push[l]) begin
                    r_mem[l][r_wr_ptr[l]] <= data_in;
                    r_wr_ptr[l]           <= r_wr_ptr[l] + 1'b1;
                end
                if (w_pop[l]) begin
                    r_rd_ptr[l] <= r_rd_ptr[l] + 1'b1;
                end
                case ({w_push[l], w_pop[l]})
                    2'b10:   r_count[l] <= r_count[l] + CW'(1);
                    2'b01:   r_count[l] <= r_count[l] - CW'(1);
                    default: r_count[l] <= r_count[l];
                endcase
            end
        end
    end

    assign data_out0  = r_mem[0][r_rd_ptr[0]];
    assign data_out1  = r_mem[1][r_rd_ptr[1]];
    assign valid_out0 = w_valid[0];
    assign valid_out1 = w_valid[1];
    assign full0      = w_full[0];
    assign full1      = w_full[1];

endmodule

// File: doc/demux_1x2_buffered.md
# demux_1x2_buffered

Receiving end of the 2-bit valid-qualified lane pair: it takes a single serialized stream (`data_in`/`valid_in`) and splits it back into lane 0 and lane 1. Words alternate lanes, starting with lane 0 after reset. Each lane has a small FIFO drained by its own `pop` signal, and `ready_in` back-pressures the source when the target lane is full. Placement is downstream of the serializing 2:1 mux stage.

## Interface
- `WIDTH`, default 2: data word width in bits.
- `DEPTH`, default 2: entries per lane FIFO. Must be a power of two and ≥ 2.
- `clk` input 1: single clock. All state updates on the rising edge.
- `reset_L` input 1: asynchronous, active-low reset. Assertion clears all state immediately. Release is synchronous to `clk`.
- `data_in` input WIDTH: incoming word.
- `valid_in` input 1: `data_in` holds a word this cycle.
- `ready_in` output 1: the lane currently selected can accept a word.
- `pop0`, `pop1` input 1 each: consume the head word of lane 0 / lane 1.
- `data_out0`, `data_out1` output WIDTH each: head word of lane 0 / lane 1.
- `valid_out0`, `valid_out1` output 1 each: lane 0 / lane 1 is non-empty.
- `full0`, `full1` output 1 each: lane 0 / lane 1 holds DEPTH words.

## Operation
**Lane selection**
- The internal `sel` flop picks the target lane: 0 selects lane 0, 1 selects lane 1.
- `ready_in = ~full[sel]`.
- A word is accepted when `valid_in & ready_in`.
- On accept: the word is written to the tail of lane `sel`, and `sel` toggles.
- When no word is accepted, `sel` holds. A stalled word keeps its lane.

**Per-lane FIFO**
- Each lane has a write pointer, a read pointer (log2(DEPTH) bits, wrapping modulo DEPTH) and a count (0..DEPTH).
- `data_out` is the combinational read of the head entry. `valid_out = (count != 0)`. `full = (count == DEPTH)`.
- Pop takes effect only when `pop & valid_out`. Popping an empty lane is ignored: no pointer or count change.
- Push and pop on the same lane in the same cycle: both occur and the count is unchanged. This is only possible when the lane is not full.
- A full lane does not accept a push even with a simultaneous pop. `ready_in` depends on `full` only, with no combinational path from `pop` to `ready_in`.
- While `valid_out` is 0, `data_out` holds the last value stored in the head slot. Consumers qualify data with `valid_out`.

**Reset**
- `sel = 0`.
- All pointers and counts = 0. All storage entries = 0.
- Outputs: `data_out0/1 = 0`, `valid_out0/1 = 0`, `full0/1 = 0`, `ready_in = 1`.
- Reset mid-operation: all buffered words are discarded. The first word after release goes to lane 0.

## Timing
- Accept in cycle N: the word is visible on `data_outX` with `valid_outX = 1` from cycle N+1, if the lane was empty.
- Pop in cycle N: the next head word (or `valid_out = 0`) appears from cycle N+1.
- `ready_in` is registered-state derived and is valid right after the clock edge. The source may therefore sample it in the same cycle it drives `valid_in`.
- Throughput is one word per cycle while neither lane blocks.
- Lane 1 full with `sel = 1` stalls the whole input, even if lane 0 has space. Strict alternation is preserved.

## Test plan
- **Reset values:** assert `reset_L = 0` asynchronously mid-cycle → all outputs go to 0 and `ready_in = 1` at once, without waiting for a clock edge.
- **Alternation:** stream 2'b01, 2'b10, 2'b11, 2'b00 with `valid_in = 1` and no pops → lane 0 holds 01, 11 (`full0 = 1`); lane 1 holds 10, 00 (`full1 = 1`); `ready_in = 0`.
- **Back-pressure:** continue from both lanes full with `valid_in = 1`, `data_in = 2'b10` for 3 cycles → no accept, `sel` stays 0. Then pulse `pop0` → `ready_in = 1` the next cycle, 10 is written to lane 0, and `sel` becomes 1.
- **Simultaneous push/pop:** lane 0 holds 1 word (2'b11); drive a push of 2'b01 to lane 0 together with `pop0` → `count0` stays 1, and `data_out0 = 01` the next cycle.
- **Empty pop and idle:** `pop1 = 1` with lane 1 empty → no state change, `valid_out1` stays 0. `valid_in = 0` for 5 cycles → `sel` unchanged.
- **Wrap-around and reset mid-stream:** push and pop 6 words per lane to wrap the pointers, checking FIFO order. Then assert reset with lane 0 holding 1 word → `valid_out0 = 0`, and the next accepted word lands in lane 0.
